// File: rtl/stim_pkg.sv
// Shared types and constants for the LCG stimulus driver and its signature compressor.
package stim_pkg;

  typedef enum logic [1:0] {
    STIM_LCG  = 2'd0,
    STIM_CNT  = 2'd1,
    STIM_WALK = 2'd2,
    STIM_HOLD = 2'd3
  } stim_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } stim_state_e;

  localparam logic [31:0] LCG_MUL_DEF = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC_DEF = 32'h0000_3039;

  function automatic int nchunk(input int width);
    return (width + 31) / 32;
  endfunction

endpackage

// File: rtl/sig_fold_misr.sv
// Folds a wide response word into 32 bits and accumulates it into a rotate-xor signature.
module sig_fold_misr
  import stim_pkg::*;
#(
  parameter int RESP_W = 159
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] data,
  output logic [31:0]       signature
);

  localparam int NC    = nchunk(RESP_W);
  localparam int PAD_W = NC * 32;

  logic [PAD_W-1:0] padded;
  logic [31:0]      fold;

  always_comb begin
    padded = '0;
    padded[RESP_W-1:0] = data;
    fold = '0;
    for (int k = 0; k < NC; k++) begin
      fold = fold ^ padded[k*32 +: 32];
    end
  end

  // Clear wins over an update arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      signature <= '0;
    end else if (en) begin
      signature <= {signature[30:0], signature[31]} ^ fold;
    end
  end

endmodule

// File: rtl/lcg_stim_driver.sv
// Builds wide stimulus vectors one 32-bit chunk per clock and presents them under valid/ready.
module lcg_stim_driver
  import stim_pkg::*;
#(
  parameter int          OUT_W   = 138,
  parameter int          RESP_W  = 159,
  parameter int          CNT_W   = 16,
  parameter logic [31:0] LCG_MUL = LCG_MUL_DEF,
  parameter logic [31:0] LCG_INC = LCG_INC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       seed,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  num_vectors,
  output logic              stim_valid,
  input  logic              stim_ready,
  output logic [OUT_W-1:0]  stim_data,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  vec_count,
  output logic [31:0]       signature
);

  localparam int NCHUNK = nchunk(OUT_W);
  localparam int PAD_W  = NCHUNK * 32;
  localparam int CI_W   = $clog2(NCHUNK + 1);
  localparam int WP_W   = $clog2(OUT_W + 1);

  stim_state_e      state, state_next;
  stim_mode_e       mode_r;
  logic [31:0]      lcg;
  logic [CI_W-1:0]  chunk_idx;
  logic [CNT_W-1:0] num_r;
  logic [WP_W-1:0]  walk_pos;

  logic             start_ok;
  logic             accept;
  logic             last_chunk;
  logic [CNT_W-1:0] count_inc;
  logic [31:0]      lcg_step;
  logic [PAD_W-1:0] walk_pad;
  logic [PAD_W-1:0] data_pad;
  logic [31:0]      chunk_val;
  logic [OUT_W-1:0] data_next;

  assign start_ok   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign accept     = (state == ST_PRESENT) && stim_ready;
  assign last_chunk = (chunk_idx == CI_W'(NCHUNK - 1));
  assign count_inc  = vec_count + 1'b1;
  assign lcg_step   = lcg * LCG_MUL + LCG_INC;

  assign stim_valid = (state == ST_PRESENT);
  assign busy       = (state == ST_FILL) || (state == ST_PRESENT);
  assign done       = (state == ST_DONE);

  // Chunk source per mode, merged into the vector under construction.
  always_comb begin
    walk_pad = PAD_W'(1) << walk_pos;
    case (mode_r)
      STIM_CNT:  chunk_val = 32'(vec_count);
      STIM_WALK: chunk_val = walk_pad[chunk_idx*32 +: 32];
      default:   chunk_val = lcg_step;
    endcase
    data_pad = '0;
    data_pad[OUT_W-1:0] = stim_data;
    data_pad[chunk_idx*32 +: 32] = chunk_val;
    data_next = data_pad[OUT_W-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_next = (num_vectors == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (last_chunk) state_next = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (stim_ready) begin
          if (count_inc == num_r)     state_next = ST_DONE;
          else if (mode_r == STIM_HOLD) state_next = ST_PRESENT;
          else                          state_next = ST_FILL;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_r    <= STIM_LCG;
      lcg       <= '0;
      stim_data <= '0;
      chunk_idx <= '0;
      vec_count <= '0;
      num_r     <= '0;
      walk_pos  <= '0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        lcg       <= seed;
        mode_r    <= stim_mode_e'(mode);
        num_r     <= num_vectors;
        vec_count <= '0;
        walk_pos  <= '0;
        chunk_idx <= '0;
      end else begin
        if (state == ST_FILL) begin
          stim_data <= data_next;
          chunk_idx <= last_chunk ? '0 : chunk_idx + 1'b1;
          if ((mode_r == STIM_LCG) || (mode_r == STIM_HOLD)) lcg <= lcg_step;
        end
        // Count reaches num_r exactly once and the FSM leaves PRESENT, so no wrap.
        if (accept) begin
          vec_count <= count_inc;
          walk_pos  <= (walk_pos == WP_W'(OUT_W - 1)) ? '0 : walk_pos + 1'b1;
        end
      end
    end
  end

  sig_fold_misr #(.RESP_W(RESP_W)) u_sig (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_ok),
    .en        (resp_valid),
    .data      (resp_data),
    .signature (signature)
  );

endmodule

// File: tb/tb_lcg_stim_driver.sv
// Directed bench for lcg_stim_driver with default parameters (OUT_W=138, RESP_W=159).
module tb_lcg_stim_driver;

  logic         clk;
  logic         rst;
  logic         start;
  logic [31:0]  seed;
  logic [1:0]   mode;
  logic [15:0]  num_vectors;
  logic         stim_valid;
  logic         stim_ready;
  logic [137:0] stim_data;
  logic         resp_valid;
  logic [158:0] resp_data;
  logic         busy;
  logic         done;
  logic [15:0]  vec_count;
  logic [31:0]  signature;

  int total = 0;
  int bad   = 0;
  logic [31:0]  mstate;
  logic [137:0] ev;
  logic [137:0] held;
  logic         have_hold;
  logic         prev_acc;
  int           cnt;
  int           xf;

  lcg_stim_driver dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seed        (seed),
    .mode        (mode),
    .num_vectors (num_vectors),
    .stim_valid  (stim_valid),
    .stim_ready  (stim_ready),
    .stim_data   (stim_data),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .busy        (busy),
    .done        (done),
    .vec_count   (vec_count),
    .signature   (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Software reference: five LCG steps per vector, top chunk truncated to 10 bits.
  task automatic gen_vec(output logic [137:0] v);
    logic [31:0] c [5];
    for (int k = 0; k < 5; k++) begin
      mstate = mstate * 32'h41C64E6D + 32'h0000_3039;
      c[k] = mstate;
    end
    v = {c[4][9:0], c[3], c[2], c[1], c[0]};
  endtask

  task automatic do_start(input logic [31:0] s, input logic [1:0] m, input logic [15:0] n);
    seed = s; mode = m; num_vectors = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!stim_valid && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; mode = '0; num_vectors = '0;
    stim_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_valid", stim_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", vec_count, 0);
    chk("rst_sig", signature, 0);
    chk("rst_data", stim_data, 0);

    // Single LCG vector from seed 1
    stim_ready = 1'b1;
    do_start(32'd1, 2'd0, 16'd1);
    wait_valid(cnt);
    chk("t1_latency", cnt + 1, 6);
    chk("t1_chunk0", stim_data[31:0], 32'h41C67EA6);
    mstate = 32'd1;
    gen_vec(ev);
    chk("t1_vec", stim_data, ev);
    chk("t1_top", stim_data[137:128], ev[137:128]);
    @(posedge clk); #1;
    chk("t1_done", done, 1);
    chk("t1_count", vec_count, 1);
    chk("t1_valid_low", stim_valid, 0);
    chk("t1_busy_low", busy, 0);

    // Seed 0, three vectors, ready toggling
    stim_ready = 1'b0;
    do_start(32'd0, 2'd0, 16'd3);
    mstate = 32'd0;
    have_hold = 1'b0;
    xf = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (have_hold) begin
        chk("t2_hold_valid", stim_valid, 1);
        chk("t2_stable", stim_data, held);
      end
      stim_ready = c[0];
      have_hold = stim_valid && !stim_ready;
      held = stim_data;
      if (stim_valid && stim_ready) begin
        gen_vec(ev);
        chk("t2_vec", stim_data, ev);
        if (xf == 0) chk("t2_chunk0", stim_data[31:0], 32'h0000_3039);
        xf++;
      end
      @(posedge clk); #1;
    end
    chk("t2_xfers", xf, 3);
    chk("t2_count", vec_count, 3);
    chk("t2_done", done, 1);

    // Walking one across 140 vectors
    stim_ready = 1'b1;
    do_start(32'd0, 2'd2, 16'd140);
    xf = 0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (stim_valid) begin
        ev = '0;
        ev[xf % 138] = 1'b1;
        chk("t3_walk", stim_data, ev);
        xf++;
      end
      @(posedge clk); #1;
    end
    chk("t3_xfers", xf, 140);
    chk("t3_count", vec_count, 140);
    chk("t3_done", done, 1);

    // Hold-first-LCG, seed 5
    do_start(32'd5, 2'd3, 16'd4);
    mstate = 32'd5;
    gen_vec(ev);
    xf = 0;
    prev_acc = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (prev_acc) chk("t4_back2back", stim_valid, 1);
      if (stim_valid) begin
        chk("t4_vec", stim_data, ev);
        xf++;
        prev_acc = (xf < 4);
      end else begin
        prev_acc = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("t4_xfers", xf, 4);
    chk("t4_done", done, 1);

    // Zero budget, then signature from two all-ones responses
    do_start(32'd7, 2'd0, 16'd0);
    chk("t5_done", done, 1);
    chk("t5_valid", stim_valid, 0);
    chk("t5_count", vec_count, 0);
    chk("t5_sig_clr", signature, 0);
    resp_valid = 1'b1;
    resp_data = '1;
    @(posedge clk); #1;
    chk("t5_sig1", signature, 32'h7FFFFFFF);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    chk("t5_sig2", signature, 32'h80000001);
    chk("t5_valid2", stim_valid, 0);

    // Start ignored while busy, then reset mid-FILL
    stim_ready = 1'b0;
    do_start(32'd1, 2'd0, 16'd2);
    mstate = 32'd1;
    gen_vec(ev);
    resp_valid = 1'b1; resp_data = 159'd1;
    seed = 32'd9; mode = 2'd1; num_vectors = 16'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; resp_valid = 1'b0;
    chk("t6_busy", busy, 1);
    chk("t6_count", vec_count, 0);
    chk("t6_sig_kept", signature, 32'h1);
    wait_valid(cnt);
    chk("t6_vec", stim_data, ev);
    stim_ready = 1'b1;
    @(posedge clk); #1;
    stim_ready = 1'b0;
    chk("t6_count1", vec_count, 1);
    chk("t6_fill", busy && !stim_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_rst_valid", stim_valid, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_count", vec_count, 0);
    chk("t6_rst_sig", signature, 0);
    chk("t6_rst_data", stim_data, 0);
    @(posedge clk); #1;
    chk("t6_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
